// File: rtl/asi_pkg.sv
// asi_pkg: shared AXI slave-interface constants and the per-beat write descriptor type
package asi_pkg;
  localparam int ASI_AW = 40;
  localparam int ASI_IW = 8;
  localparam int ASI_DW = 128;
  localparam int ASI_SLV_BYTES = ASI_DW / 8;
  typedef enum logic [1:0] {BT_FIXED = 2'd0, BT_INCR = 2'd1, BT_WRAP = 2'd2, BT_RESERVED = 2'd3} burst_e;
  localparam logic [7:0] WRAP_BL_2 = 8'd1;
  localparam logic [7:0] WRAP_BL_4 = 8'd3;
  localparam logic [7:0] WRAP_BL_8 = 8'd7;
  localparam logic [7:0] WRAP_BL_16 = 8'd15;
  localparam logic [2:0] TRSIZE_1B = 3'd0;
  localparam logic [2:0] TRSIZE_2B = 3'd1;
  localparam logic [2:0] TRSIZE_4B = 3'd2;
  localparam logic [2:0] TRSIZE_8B = 3'd3;
  localparam logic [2:0] TRSIZE_16B = 3'd4;
  localparam logic [2:0] TRSIZE_32B = 3'd5;
  localparam logic [2:0] TRSIZE_64B = 3'd6;
  localparam logic [2:0] TRSIZE_128B = 3'd7;
  typedef struct packed {
    logic [ASI_AW-1:0] addr;
    logic [ASI_SLV_BYTES-1:0] mask;
    logic last;
    logic [ASI_IW-1:0] id;
    logic err;
  } asi_beat_t;
endpackage

// File: rtl/asi_beat_mask.sv
// asi_beat_mask: byte-lane mask for one beat from the address low bits and effective size
module asi_beat_mask #(
  parameter int SB = 16,
  parameter int SW = 3,
  localparam int LB = $clog2(SB)
) (
  input  logic [LB-1:0] addr,
  input  logic [SW-1:0] esz,
  output logic [SB-1:0] mask
);
  logic [LB-1:0] bm, hi;
  for (genvar k = 0; k < LB; k++) assign bm[k] = esz > SW'(k);
  // aligned + B - 1 equals addr | (B-1) because the aligned low bits are zero
  assign hi = addr | bm;
  for (genvar i = 0; i < SB; i++) assign mask[i] = LB'(i) >= addr && LB'(i) <= hi;
endmodule

// File: rtl/asi_aw_addr_gen.sv
// asi_aw_addr_gen: expands AXI AW commands into per-beat descriptors; ASI_AW_4K_CHECK_EN flags INCR bursts crossing a 4KB page
module asi_aw_addr_gen
  import asi_pkg::*;
#(
  parameter int AXI_AW = 40,
  parameter int AXI_IW = 8,
  parameter int AXI_LW = 8,
  parameter int AXI_SW = 3,
  parameter int AXI_DW = 128
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [AXI_AW-1:0]   cmd_addr,
  input  logic [AXI_LW-1:0]   cmd_len,
  input  logic [AXI_SW-1:0]   cmd_size,
  input  logic [1:0]          cmd_burst,
  input  logic [AXI_IW-1:0]   cmd_id,
  output logic                beat_valid,
  input  logic                beat_ready,
  output logic [AXI_AW-1:0]   beat_addr,
  output logic [AXI_DW/8-1:0] beat_mask,
  output logic                beat_last,
  output logic [AXI_IW-1:0]   beat_id,
  output logic                beat_err
);
  localparam int SB = AXI_DW / 8;
  localparam int LB = $clog2(SB);
  typedef enum logic {IDLE, BURST} state_t;
  state_t state;
  logic [1:0] mode, c_mode;
  logic [AXI_SW-1:0] esz, c_esz, m_esz;
  logic [AXI_AW-1:0] wmask, c_wmask, c_b, b, inc, n_addr;
  logic [AXI_LW-1:0] cnt;
  logic [LB-1:0] m_addr;
  logic [SB-1:0] n_mask;
  logic take, adv, c_wrap_ok, c_err, c_page;
  assign cmd_ready = state == IDLE || (beat_valid && beat_ready && beat_last);
  assign take = cmd_valid && cmd_ready;
  assign adv = beat_valid && beat_ready && !beat_last;
  always_comb begin
    c_esz = cmd_size > AXI_SW'(LB) ? AXI_SW'(LB) : cmd_size;
    c_b = AXI_AW'(1) << c_esz;
    c_wmask = (AXI_AW'(cmd_len) << c_esz) | (c_b - AXI_AW'(1));
    c_wrap_ok = (cmd_len == AXI_LW'(WRAP_BL_2) || cmd_len == AXI_LW'(WRAP_BL_4) ||
                 cmd_len == AXI_LW'(WRAP_BL_8) || cmd_len == AXI_LW'(WRAP_BL_16)) &&
                (cmd_addr & (c_b - AXI_AW'(1))) == '0;
    c_mode = cmd_burst == BT_FIXED ? BT_FIXED : (cmd_burst == BT_WRAP && c_wrap_ok) ? BT_WRAP : BT_INCR;
    c_err = cmd_burst == BT_RESERVED || (cmd_burst == BT_WRAP && !c_wrap_ok) || cmd_size > AXI_SW'(LB);
    b = AXI_AW'(1) << esz;
    inc = (beat_addr & ~(b - AXI_AW'(1))) + b;
    // wrap window is W-aligned, so the window base bits come from the current address
    n_addr = mode == BT_FIXED ? beat_addr : mode == BT_WRAP ? (beat_addr & ~wmask) | (inc & wmask) : inc;
    m_addr = take ? cmd_addr[LB-1:0] : n_addr[LB-1:0];
    m_esz = take ? c_esz : esz;
  end
`ifdef ASI_AW_4K_CHECK_EN
  logic [AXI_AW-1:0] c_end;
  always_comb begin
    c_end = (cmd_addr & ~(c_b - AXI_AW'(1))) + ((AXI_AW'(cmd_len) + AXI_AW'(1)) << c_esz) - AXI_AW'(1);
    c_page = cmd_burst == BT_INCR && (c_end >> 12) != (cmd_addr >> 12);
  end
`else
  assign c_page = 1'b0;
`endif
  asi_beat_mask #(.SB(SB), .SW(AXI_SW)) u_mask (.addr(m_addr), .esz(m_esz), .mask(n_mask));
  always_ff @(posedge ACLK)
    if (ARESET) begin
      state <= IDLE;
      beat_valid <= 1'b0;
      beat_addr <= '0;
      beat_mask <= '0;
      beat_last <= 1'b0;
      beat_id <= '0;
      beat_err <= 1'b0;
      cnt <= '0;
      esz <= '0;
      wmask <= '0;
      mode <= BT_FIXED;
    end else if (take) begin
      state <= BURST;
      beat_valid <= 1'b1;
      beat_addr <= cmd_addr;
      beat_mask <= n_mask;
      beat_last <= cmd_len == '0;
      beat_id <= cmd_id;
      beat_err <= c_err || c_page;
      cnt <= cmd_len;
      esz <= c_esz;
      wmask <= c_wmask;
      mode <= c_mode;
    end else if (adv) begin
      beat_addr <= n_addr;
      beat_mask <= n_mask;
      beat_last <= cnt == AXI_LW'(1);
      cnt <= cnt - AXI_LW'(1);
    end else if (beat_valid && beat_ready) begin
      state <= IDLE;
      beat_valid <= 1'b0;
      beat_last <= 1'b0;
    end
endmodule

// File: tb/tb_asi_aw_addr_gen.sv
// tb_asi_aw_addr_gen: directed vectors with hand-computed descriptors for asi_aw_addr_gen
module tb_asi_aw_addr_gen;
  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid, cmd_ready;
  logic [39:0]  cmd_addr;
  logic [7:0]   cmd_len;
  logic [2:0]   cmd_size;
  logic [1:0]   cmd_burst;
  logic [7:0]   cmd_id;
  logic         beat_valid, beat_ready, beat_last, beat_err;
  logic [39:0]  beat_addr;
  logic [15:0]  beat_mask;
  logic [7:0]   beat_id;
  int n_tests = 0;
  int n_fail = 0;
`ifdef ASI_AW_4K_CHECK_EN
  localparam logic PG = 1'b1;
`else
  localparam logic PG = 1'b0;
`endif
  asi_aw_addr_gen dut (
    .ACLK(clk), .ARESET(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .cmd_size(cmd_size), .cmd_burst(cmd_burst), .cmd_id(cmd_id),
    .beat_valid(beat_valid), .beat_ready(beat_ready), .beat_addr(beat_addr), .beat_mask(beat_mask),
    .beat_last(beat_last), .beat_id(beat_id), .beat_err(beat_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [39:0] a, input logic [7:0] l, input logic [2:0] s, input logic [1:0] bt, input logic [7:0] id);
    cmd_addr = a;
    cmd_len = l;
    cmd_size = s;
    cmd_burst = bt;
    cmd_id = id;
    cmd_valid = 1'b1;
    chk("cmd_ready", cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
  endtask
  task automatic beat(input string tag, input logic [39:0] a, input logic [15:0] m, input logic l, input logic e);
    chk({tag, ".valid"}, beat_valid, 1);
    chk({tag, ".addr"}, beat_addr, a);
    chk({tag, ".mask"}, beat_mask, m);
    chk({tag, ".last"}, beat_last, l);
    chk({tag, ".err"}, beat_err, e);
    step();
  endtask
  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr = '0;
    cmd_len = '0;
    cmd_size = '0;
    cmd_burst = '0;
    cmd_id = '0;
    beat_ready = 1'b1;
    step();
    step();
    chk("rst.valid", beat_valid, 0);
    chk("rst.ready", cmd_ready, 1);
    chk("rst.addr", beat_addr, 0);
    chk("rst.mask", beat_mask, 0);
    chk("rst.last", beat_last, 0);
    chk("rst.id", beat_id, 0);
    chk("rst.err", beat_err, 0);
    rst = 1'b0;
    step();
    // INCR with unaligned start
    send(40'h1004, 8'd3, 3'd4, 2'd1, 8'h11);
    chk("incr.id", beat_id, 8'h11);
    chk("incr.busy", cmd_ready, 0);
    beat("incr0", 40'h1004, 16'hFFF0, 0, 0);
    beat("incr1", 40'h1010, 16'hFFFF, 0, 0);
    beat("incr2", 40'h1020, 16'hFFFF, 0, 0);
    beat("incr3", 40'h1030, 16'hFFFF, 1, 0);
    chk("incr.idle", beat_valid, 0);
    // WRAP 32-byte window
    send(40'h38, 8'd3, 3'd3, 2'd2, 8'h22);
    beat("wrap0", 40'h38, 16'hFF00, 0, 0);
    beat("wrap1", 40'h20, 16'h00FF, 0, 0);
    beat("wrap2", 40'h28, 16'hFF00, 0, 0);
    beat("wrap3", 40'h30, 16'h00FF, 1, 0);
    // FIXED with stalls: outputs must hold while beat_ready is low
    send(40'h104, 8'd2, 3'd2, 2'd0, 8'h33);
    for (int j = 0; j < 3; j++) begin
      beat_ready = 1'b0;
      step();
      chk("fixed.hold.valid", beat_valid, 1);
      chk("fixed.hold.addr", beat_addr, 40'h104);
      chk("fixed.hold.mask", beat_mask, 16'h00F0);
      chk("fixed.hold.last", beat_last, j == 2);
      beat_ready = 1'b1;
      beat("fixed", 40'h104, 16'h00F0, j == 2, 0);
    end
    chk("fixed.idle", beat_valid, 0);
    // back-to-back acceptance on the last beat
    send(40'h0, 8'd1, 3'd4, 2'd1, 8'h01);
    beat("b2b0", 40'h0, 16'hFFFF, 0, 0);
    cmd_addr = 40'h200;
    cmd_len = 8'd0;
    cmd_size = 3'd4;
    cmd_burst = 2'd1;
    cmd_id = 8'h02;
    cmd_valid = 1'b1;
    chk("b2b.ready", cmd_ready, 1);
    beat("b2b1", 40'h10, 16'hFFFF, 1, 0);
    cmd_valid = 1'b0;
    chk("b2b.id", beat_id, 8'h02);
    beat("b2b2", 40'h200, 16'hFFFF, 1, 0);
    chk("b2b.idle", beat_valid, 0);
    // error cases
    send(40'h1004, 8'd1, 3'd4, 2'd3, 8'h44);
    beat("rsv0", 40'h1004, 16'hFFF0, 0, 1);
    beat("rsv1", 40'h1010, 16'hFFFF, 1, 1);
    send(40'h40, 8'd2, 3'd3, 2'd2, 8'h55);
    beat("wlen0", 40'h40, 16'h00FF, 0, 1);
    beat("wlen1", 40'h48, 16'hFF00, 0, 1);
    beat("wlen2", 40'h50, 16'h00FF, 1, 1);
    send(40'h34, 8'd3, 3'd3, 2'd2, 8'h56);
    beat("wal0", 40'h34, 16'h00F0, 0, 1);
    beat("wal1", 40'h38, 16'hFF00, 0, 1);
    beat("wal2", 40'h40, 16'h00FF, 0, 1);
    beat("wal3", 40'h48, 16'hFF00, 1, 1);
    send(40'h0, 8'd1, 3'd6, 2'd1, 8'h66);
    beat("clamp0", 40'h0, 16'hFFFF, 0, 1);
    beat("clamp1", 40'h10, 16'hFFFF, 1, 1);
    // reset during beat 2 of 8
    send(40'h0, 8'd7, 3'd4, 2'd1, 8'h77);
    beat("ar0", 40'h0, 16'hFFFF, 0, 0);
    chk("ar.beat2", beat_addr, 40'h10);
    rst = 1'b1;
    step();
    chk("ar.valid", beat_valid, 0);
    chk("ar.ready", cmd_ready, 1);
    chk("ar.addr", beat_addr, 0);
    chk("ar.id", beat_id, 0);
    rst = 1'b0;
    step();
    chk("ar.quiet", beat_valid, 0);
    // 4KB page crossing
    send(40'hFF0, 8'd1, 3'd4, 2'd1, 8'h88);
    beat("pg0", 40'hFF0, 16'hFFFF, 0, PG);
    beat("pg1", 40'h1000, 16'hFFFF, 1, PG);
    chk("pg.idle", beat_valid, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/asi_aw_addr_gen.md
Name: asi_aw_addr_gen

Overview:
- Write-address-path stage directly upstream of asi_w.
- Accepts one accepted AXI AW command (addr/len/size/burst/id) and expands it into one per-beat descriptor per W beat.
- Each descriptor carries beat address, byte-lane mask, last flag, id and an error flag, so asi_w can steer WDATA/WSTRB into slave storage.
- Implements AXI FIXED/INCR/WRAP address sequencing with back-to-back command acceptance.

Parameters:
- AXI_AW, 40, address width.
- AXI_IW, 8, ID width.
- AXI_LW, 8, burst length field width.
- AXI_SW, 3, size field width.
- AXI_DW, 128, data bus width; SLV_BYTES = AXI_DW/8 lanes.

Ports:
- ACLK  in  1  clock; all logic rising-edge.
- ARESET  in  1  reset; synchronous, active-high.
- cmd_valid  in  1  AW command valid.
- cmd_ready  out  1  command accept.
- cmd_addr  in  AXI_AW  start address.
- cmd_len  in  AXI_LW  beats-1.
- cmd_size  in  AXI_SW  log2 bytes per beat.
- cmd_burst  in  2  FIXED=0, INCR=1, WRAP=2, RESERVED=3.
- cmd_id  in  AXI_IW  transaction id.
- beat_valid  out  1  descriptor valid.
- beat_ready  in  1  asi_w consumes descriptor.
- beat_addr  out  AXI_AW  address of this beat.
- beat_mask  out  AXI_DW/8  byte lanes legal for this beat.
- beat_last  out  1  final beat of burst.
- beat_id  out  AXI_IW  id of owning command.
- beat_err  out  1  command was illegal (held for whole burst).

Behaviour:
- Reset: state=IDLE; cmd_ready=1; beat_valid=0, beat_last=0, beat_err=0; beat_addr, beat_mask, beat_id all 0.
- FSM IDLE: cmd_ready=1. On cmd_valid&cmd_ready: latch the command, load the first descriptor, go BURST. beat_valid rises the cycle after the handshake (latency 1).
- FSM BURST: beat_valid=1. On beat_valid&beat_ready:
  - If not last: advance address, decrement remaining count, stay in BURST.
  - If last and cmd_valid is high: accept the next command that same cycle (cmd_ready = beat_last&beat_ready) and present its first beat next cycle (no bubble).
  - If last and cmd_valid is low: go IDLE.
- cmd_ready = (state==IDLE) | (beat_valid & beat_ready & beat_last).
- Outputs are stable while beat_valid & !beat_ready.
- Remaining-beat counter is AXI_LW bits, loaded with cmd_len. beat_last=1 when counter==0.
- Effective size esz = min(cmd_size, log2(SLV_BYTES)). Bytes per beat B = 1<<esz. aligned = addr & ~(B-1).
- FIXED: every beat uses cmd_addr.
- INCR: first beat uses cmd_addr; next = aligned+B, modulo 2^AXI_AW (silent wrap at top of address space).
- WRAP: span W = B*(len+1); lower bound = addr & ~(W-1). Next = aligned+B; if next == lower+W, next = lower.
- beat_mask: bits [addr mod SLV_BYTES .. (aligned mod SLV_BYTES)+B-1] set, all other bits clear. An unaligned first beat masks off the low lanes.
- beat_err=1 for the whole burst when any of these holds:
  - cmd_burst==RESERVED: sequenced as INCR.
  - WRAP with len not in {1,3,7,15}: sequenced as INCR.
  - WRAP with cmd_addr not size-aligned: sequenced as INCR.
  - cmd_size > log2(SLV_BYTES): size clamped to esz.
- ARESET mid-burst: burst is abandoned, outputs return to their reset values next cycle, no further beats emitted.
- len=0: single beat, beat_last=1 on the first descriptor.

Optional Feature:
- Macro ASI_AW_4K_CHECK_EN.
- Defined:
  - INCR bursts whose final byte (aligned_start + B*(len+1) - 1) lies in a different 4KB page than cmd_addr set beat_err for the whole burst.
  - Addresses still sequence linearly.
  - Adds one 13-bit compare at command load.
- Undefined: no page check; beat_err is driven only by the base error rules.

Decomposition:
- Shared package asi_pkg supplies:
  - BT_FIXED/BT_INCR/BT_WRAP/BT_RESERVED.
  - WRAP_BL_2/4/8/16.
  - TRSIZE_* constants.
  - A new typedef asi_beat_t {addr, mask, last, id, err} consumed by asi_w.
- Natural sub-module: asi_beat_mask, combinational mask generator (addr low bits + esz -> beat_mask), reusable by the read path.

Test Plan:
- INCR, addr=0x1004, len=3, size=4 -> addrs 0x1004, 0x1010, 0x1020, 0x1030; first mask=0xFFF0, then 0xFFFF; last on beat 4; err=0.
- WRAP, addr=0x38, len=3, size=3 -> addrs 0x38, 0x20, 0x28, 0x30; masks 0xFF00, 0x00FF, 0xFF00, 0x00FF.
- FIXED, addr=0x104, len=2, size=2, beat_ready toggled 1/0 -> three beats all at 0x104, mask 0x00F0; outputs held while stalled.
- Back-to-back: second cmd_valid asserted during first command's last beat with beat_ready=1 -> cmd_ready=1 that cycle; next cycle shows the second command's first beat with no bubble.
- Errors: burst=3 -> err=1, sequenced as INCR. WRAP len=2 -> err=1. ARESET during beat 2 of 8 -> beat_valid=0 and state IDLE the next cycle.
- With ASI_AW_4K_CHECK_EN: INCR addr=0xFF0, len=1, size=4 -> err=1. Without the macro, same stimulus -> err=0.
